// File: rtl/upsampler_pkg.sv
// Shared types and helpers for the upsampler and its phase counter.
package upsampler_pkg;

  localparam int unsigned DEF_WIDTH  = 8;
  localparam int unsigned DEF_FACTOR = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } upsampler_state_e;

  typedef logic signed [7:0] sample_t;

  // Counter width for a modulo-n count, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/upsampler_if.sv
// Sample-in / sample-out handshake bundle for the upsampler.
interface upsampler_if #(
  parameter int unsigned WIDTH = 8
);
  logic signed [WIDTH-1:0] in;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] out;
  logic                    out_valid;
  logic                    out_ready;

  modport slave (
    input  in, in_valid, out_ready,
    output in_ready, out, out_valid
  );

  modport master (
    output in, in_valid, out_ready,
    input  in_ready, out, out_valid
  );
endinterface

// File: rtl/upsampler_mod_counter.sv
// Modulo-N counter with synchronous clear; wrap flags the last count.
module mod_counter
  import upsampler_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned W = cnt_width(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         wrap
);

  logic [W-1:0] count_q, count_d;

  assign wrap = (count_q == W'(N - 1));

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = wrap ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/upsampler.sv
// Integer-factor upsampler: each input becomes FACTOR output beats.
// Define UPSAMPLER_HOLD_EN for zero-order hold instead of zero stuffing.
module upsampler
  import upsampler_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned FACTOR = DEF_FACTOR
) (
  input  logic     clk,
  input  logic     rst,
  upsampler_if.slave bus
);

  localparam int unsigned CNT_W  = cnt_width(FACTOR);
  localparam logic [0:0]  S_IDLE = IDLE;
  localparam logic [0:0]  S_EMIT = EMIT;

  logic [0:0]              state_q, state_d;
  logic signed [WIDTH-1:0] out_q, out_d;
  logic                    out_valid_q, out_valid_d;
  logic [CNT_W-1:0]        phase;
  logic                    wrap;
  logic                    in_xfer;
  logic                    out_xfer;
  logic signed [WIDTH-1:0] fill;

  assign bus.in_ready = (state_q == S_IDLE) ||
                        ((phase == CNT_W'(FACTOR - 1)) && bus.out_ready);
  assign in_xfer  = bus.in_valid && bus.in_ready;
  assign out_xfer = out_valid_q && bus.out_ready;

`ifdef UPSAMPLER_HOLD_EN
  assign fill = out_q;
`else
  assign fill = '0;
`endif

  // Phase advances once per delivered beat and rolls over after the last one.
  mod_counter #(
    .N (FACTOR)
  ) u_phase (
    .clk   (clk),
    .rst   (rst),
    .en    (out_xfer),
    .clr   (state_q == S_IDLE),
    .count (phase),
    .wrap  (wrap)
  );

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_xfer) begin
          out_d       = bus.in;
          out_valid_d = 1'b1;
          state_d     = S_EMIT;
        end
      end
      S_EMIT: begin
        if (out_xfer) begin
          if (!wrap) begin
            out_d = fill;
          end else if (in_xfer) begin
            out_d = bus.in;
          end else begin
            out_d       = '0;
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
          end
        end
      end
      default: begin
        out_d       = '0;
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;

endmodule
